// File: rtl/quad_enumerator.sv
// -----------------------------------------------------------------------------
// quad_enumerator
//
// Holds a 16-entry array of unsigned W-bit values. On start it walks every
// index quadruple i<j<k<l in lexicographic order, one candidate per cycle,
// and presents each quadruple whose element sum equals the latched target
// on a valid/ready output port.
//
// Optional feature: define QUAD_ENUM_COUNT_EN to add the match_count port,
// which counts the matches handed off during the most recent run.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        array write strobe (ignored while busy)
//   wr_addr      element index 0..15
//   wr_data      element value
//   start        begin an enumeration (ignored while busy)
//   target       quadruple sum to match, W+2 bits
//   busy         high from the cycle after an accepted start until done
//   out_valid    a matching quadruple is presented
//   out_ready    consumer accepts the presented quadruple
//   out_i..out_l indices of the match, out_i<out_j<out_k<out_l
//   done         one-cycle pulse at the end of a run
//   match_count  matches of the last run (QUAD_ENUM_COUNT_EN only)
// -----------------------------------------------------------------------------
module quad_enumerator #(
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic [3:0]     wr_addr,
   input  logic [W-1:0]   wr_data,
   input  logic           start,
   input  logic [W+1:0]   target,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [3:0]     out_i,
   output logic [3:0]     out_j,
   output logic [3:0]     out_k,
   output logic [3:0]     out_l,
   output logic           done
`ifdef QUAD_ENUM_COUNT_EN
   ,
   output logic [11:0]    match_count
`endif
);

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

   typedef struct packed {
      logic [3:0] i;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] l;
   } quad_t;

   localparam quad_t FIRST_QUAD = '{i: 4'd0,  j: 4'd1,  k: 4'd2,  l: 4'd3};
   localparam quad_t LAST_QUAD  = '{i: 4'd12, j: 4'd13, k: 4'd14, l: 4'd15};

   state_t         state, state_nxt;
   quad_t          cur, cur_nxt, adv;
   logic [W-1:0]   mem [N];
   logic [W+1:0]   tgt;
   logic [W+1:0]   sum;
   logic           is_last;
   logic           accept_start;

   assign accept_start = (state == IDLE) && start;
   assign is_last      = (cur == LAST_QUAD);

   // Zero-extend each element before adding so four maximal values still fit.
   assign sum = {2'b00, mem[cur.i]} + {2'b00, mem[cur.j]}
              + {2'b00, mem[cur.k]} + {2'b00, mem[cur.l]};

   // Lexicographic successor: bump the rightmost index that still has room,
   // then pack every index to its right as tightly as possible.
   always_comb begin
      adv = cur;
      if (cur.l != 4'd15) begin
         adv.l = cur.l + 4'd1;
      end else if (cur.k != 4'd14) begin
         adv.k = cur.k + 4'd1;
         adv.l = cur.k + 4'd2;
      end else if (cur.j != 4'd13) begin
         adv.j = cur.j + 4'd1;
         adv.k = cur.j + 4'd2;
         adv.l = cur.j + 4'd3;
      end else begin
         adv.i = cur.i + 4'd1;
         adv.j = cur.i + 4'd2;
         adv.k = cur.i + 4'd3;
         adv.l = cur.i + 4'd4;
      end
   end

   // NOTE: every signal driven here gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SCAN;
               cur_nxt   = FIRST_QUAD;
            end
         end
         SCAN: begin
            if (sum == tgt) begin
               state_nxt = EMIT;
            end else if (is_last) begin
               state_nxt = FIN;
            end else begin
               cur_nxt = adv;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (is_last) begin
                  state_nxt = FIN;
               end else begin
                  state_nxt = SCAN;
                  cur_nxt   = adv;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cur   <= '0;
         tgt   <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         if (accept_start) begin
            tgt <= target;
         end
      end
   end

   // NOTE: the element array is cleared by reset on purpose so a run started
   // right after reset sees defined zeros; it is small enough to live in flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < N; e++) begin
            mem[e] <= '0;
         end
      end else if (wr_en && !busy) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef QUAD_ENUM_COUNT_EN
   // Counts completed handshakes only, so a stalled match is counted once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_count <= '0;
      end else if (accept_start) begin
         match_count <= '0;
      end else if ((state == EMIT) && out_ready) begin
         match_count <= match_count + 12'd1;
      end
   end
`endif

   assign busy      = (state != IDLE);
   assign out_valid = (state == EMIT);
   assign done      = (state == FIN);
   assign out_i     = cur.i;
   assign out_j     = cur.j;
   assign out_k     = cur.k;
   assign out_l     = cur.l;

endmodule

// File: tb/tb_quad_enumerator.sv
// -----------------------------------------------------------------------------
// tb_quad_enumerator
//
// Scoreboard bench for quad_enumerator. Each run loads the array, enumerates
// all matching quadruples with plain nested loops into an expected queue, and
// starts the DUT. A monitor pops the queue on every output handshake and
// checks that stalled outputs hold steady. Ready behaviour per run: always
// high, random, five-cycle stall per match, or held low.
// -----------------------------------------------------------------------------
module tb_quad_enumerator;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           wr_en = 1'b0;
   logic [3:0]     wr_addr = '0;
   logic [W-1:0]   wr_data = '0;
   logic           start = 1'b0;
   logic [W+1:0]   target = '0;
   logic           busy;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [3:0]     out_i, out_j, out_k, out_l;
   logic           done;
`ifdef QUAD_ENUM_COUNT_EN
   logic [11:0]    match_count;
`endif

   quad_enumerator #(.N(16), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .target      (target),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_i       (out_i),
      .out_j       (out_j),
      .out_k       (out_k),
      .out_l       (out_l),
      .done        (done)
`ifdef QUAD_ENUM_COUNT_EN
      ,
      .match_count (match_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  arr [16];
   logic [15:0] exp_q [$];
   int          n_exp;
   int          done_seen = 0;
   int          ready_mode = 0;   // 0 high, 1 random, 2 stall 5, 3 low
   int          stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: brute-force every i<j<k<l in lexicographic order.
   task automatic build_model(input logic [W+1:0] t);
      exp_q.delete();
      for (int i = 0; i < 16; i++)
         for (int j = i + 1; j < 16; j++)
            for (int k = j + 1; k < 16; k++)
               for (int l = k + 1; l < 16; l++)
                  if (int'(arr[i]) + int'(arr[j]) + int'(arr[k]) + int'(arr[l]) == int'(t))
                     exp_q.push_back({4'(i), 4'(j), 4'(k), 4'(l)});
      n_exp = exp_q.size();
   endtask

   // Ready driver, updated just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid) stall++;
               else stall = 0;
               out_ready = (stall >= 5);
            end
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares on every handshake, checks stability while stalled.
   initial begin
      logic [15:0] held;
      bit          stalled;
      logic [15:0] got;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            continue;
         end
         got = {out_i, out_j, out_k, out_l};
         if (out_valid) begin
            if (stalled) check("stall_hold", 32'(got), 32'(held));
            if (out_ready) begin
               stalled = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_match", 32'(got), 32'hFFFF);
               end else begin
                  check("quad", 32'(got), 32'(exp_q.pop_front()));
               end
            end else begin
               stalled = 1'b1;
               held    = got;
            end
         end else begin
            stalled = 1'b0;
         end
         if (done) done_seen++;
      end
   end

   task automatic write_elem(input int a, input logic [7:0] d);
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = d;
      arr[a]  = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   // One full enumeration; returns the cycle index (1 = first SCAN cycle)
   // at which done was seen.
   task automatic run_test(input logic [W+1:0] t, input int rmode,
                           input bit disturb, output int cyc);
      build_model(t);
      ready_mode = rmode;
      done_seen  = 0;
      @(posedge clk);
      #1;
      start  = 1'b1;
      target = t;
      @(posedge clk);
      #1;
      start  = 1'b0;
      target = 10'(~t);
      cyc = 1;
      check("busy_after_start", 32'(busy), 1);
      while (!done && cyc < 40000) begin
         if (disturb && cyc == 50) begin
            wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'd7;
            start = 1'b1; target = '0;
         end else if (disturb && cyc == 51) begin
            wr_en = 1'b0; start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done_reached", 32'(done), 1);
      @(posedge clk);
      #1;
      check("busy_after_done", 32'(busy), 0);
      check("done_one_cycle", 32'(done), 0);
      @(negedge clk);
      check("done_count", 32'(done_seen), 1);
      check("matches_left", 32'(exp_q.size()), 0);
`ifdef QUAD_ENUM_COUNT_EN
      check("match_count", 32'(match_count), 32'(n_exp));
`endif
   endtask

   initial begin
      int cyc;
      for (int e = 0; e < 16; e++) arr[e] = '0;

      #23;
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_done", 32'(done), 0);
      check("rst_idx", 32'({out_i, out_j, out_k, out_l}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // All ones, target 4: every combination matches.
      for (int e = 0; e < 16; e++) write_elem(e, 8'd1);
      run_test(10'd4, 0, 1'b0, cyc);
      check("run_len_all", 32'(cyc <= 1820 + 2 * 1820 + 2), 1);

      // a[k]=k, target 6: only (0,1,2,3).
      for (int e = 0; e < 16; e++) write_elem(e, 8'(e));
      run_test(10'd6, 1, 1'b0, cyc);
      check("single_match_n", 32'(n_exp), 1);

      // a[k]=k, target 100: no match, minimum run length.
      run_test(10'd100, 0, 1'b0, cyc);
      check("run_len_none", 32'(cyc >= 1820 && cyc <= 1822), 1);

      // All 255, target 1020, five-cycle stall per match.
      for (int e = 0; e < 16; e++) write_elem(e, 8'd255);
      run_test(10'd1020, 2, 1'b0, cyc);

      // Writes and a second start during a run must not disturb it.
      for (int e = 0; e < 16; e++) write_elem(e, 8'd1);
      run_test(10'd4, 0, 1'b1, cyc);

      // Randomized arrays and targets with random backpressure.
      for (int r = 0; r < 3; r++) begin
         for (int e = 0; e < 16; e++) write_elem(e, 8'($urandom_range(0, 3)));
         run_test(10'($urandom_range(0, 12)), 1, 1'b0, cyc);
      end

      // Reset in the middle of a stalled EMIT.
      for (int e = 0; e < 16; e++) write_elem(e, 8'd1);
      build_model(10'd4);
      ready_mode = 3;
      done_seen  = 0;
      @(posedge clk);
      #1;
      start = 1'b1; target = 10'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("emit_reached", 32'(out_valid), 1);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_idx", 32'({out_i, out_j, out_k, out_l}), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_done", 32'(done_seen), 0);
      check("midrst_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_enumerator.md
QUAD_ENUMERATOR -- requirements
Module: quad_enumerator

Interface
REQ-001 Parameter N, default 16: number of array elements; fixed at 16 for this revision.
REQ-002 Parameter W, default 8: element width in bits, unsigned.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  array write strobe.
REQ-006 wr_addr  input  4  element index 0..15.
REQ-007 wr_data  input  W  element value.
REQ-008 start  input  1  begin enumeration pulse.
REQ-009 target  input  W+2  quadruple sum to match, unsigned.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 out_valid  output  1  matching quadruple is presented.
REQ-012 out_ready  input  1  consumer accepts quadruple.
REQ-013 out_i, out_j, out_k, out_l  output  4 each  indices of the match, out_i<out_j<out_k<out_l.
REQ-014 done  output  1  one-cycle pulse at end of enumeration.
REQ-015 match_count  output  12  total matches of the last run (present only with QUAD_ENUM_COUNT_EN).

Function
REQ-016 Array store SHALL be 16 x W registers; write occurs when wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, SCAN, EMIT, FIN.
REQ-018 IDLE: start=1 SHALL latch target, set indices to (0,1,2,3), assert busy next cycle, go SCAN.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 SCAN: evaluate one combination per cycle; sum = zero-extended a[i]+a[j]+a[k]+a[l] in W+2 bits, no overflow possible.
REQ-021 SCAN, sum==target: go EMIT holding indices; out_valid=1 from the next cycle.
REQ-022 SCAN, no match: advance to next combination in lexicographic order; if current is (12,13,14,15) go FIN.
REQ-023 Advance rule: increment l if l<15; else increment k with l=k+1 if k<14; else increment j with k=j+1,l=j+2 if j<13; else increment i with j=i+1,k=i+2,l=i+3.
REQ-024 EMIT: out_valid and out_* SHALL stay stable until out_valid&&out_ready; on that cycle advance and go SCAN, or go FIN if combination was (12,13,14,15).
REQ-025 out_valid SHALL be 0 in every state except EMIT.
REQ-026 FIN: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
REQ-027 Each of the 1820 combinations SHALL be evaluated exactly once per run; matches emitted in lexicographic order, none duplicated.
REQ-028 Worst-case run length with out_ready tied high: 1820 + 2*matches + 2 cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, out_valid=0, done=0, out_*=0, match_count=0, array=0, latched target=0.
REQ-030 Reset mid-run SHALL abandon the run without done pulse; no output handshake completes after reset assertion.

Configuration
REQ-031 Macro QUAD_ENUM_COUNT_EN defined: match_count port present; cleared on accepted start, incremented on each EMIT handshake, held stable from FIN until next start.
REQ-032 Macro QUAD_ENUM_COUNT_EN undefined: match_count port and counter absent; all other behaviour identical.

Verification
REQ-033 All elements=1, target=4, out_ready=1 -> 1820 handshakes, first (0,1,2,3), last (12,13,14,15), done once, match_count=1820.
REQ-034 a[k]=k, target=6 -> exactly one match (0,1,2,3), done, match_count=1.
REQ-035 All elements=255, target=1020 with out_ready low 5 cycles per match -> out_* stable while stalled, 1820 matches, no loss.
REQ-036 a[k]=k, target=100 -> no out_valid, done after 1820+2 cycles, match_count=0.
REQ-037 wr_en and second start during run, then rst_n=0 mid-EMIT -> writes/start ignored, outputs zero immediately, no done pulse.
